// File: rtl/fw_ram_scrubber_pkg.sv
// Shared state encoding, default parameters and bus constants for the FW RAM scrubber.
package fw_ram_scrubber_pkg;

  localparam int unsigned DEF_NUM_WORDS = 32'd512;
  localparam logic [31:0] DEF_FILL_WORD = 32'h0000_0000;
  localparam int unsigned DEF_TIMEOUT   = 32'd16;

  localparam int unsigned ADDR_W = 32'd9;
  localparam int unsigned DATA_W = 32'd32;

  localparam logic [3:0] WE_WRITE = 4'hf;
  localparam logic [3:0] WE_READ  = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WGAP   = 3'd2,
    ST_READ   = 3'd3,
    ST_RGAP   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // States that drive a bus request and wait for the responder ack.
  function automatic logic is_access(input state_t s);
    return (s == ST_WRITE) || (s == ST_READ);
  endfunction

  function automatic logic is_active(input state_t s);
    return (s == ST_WRITE) || (s == ST_WGAP) || (s == ST_READ) || (s == ST_RGAP);
  endfunction

endpackage

// File: rtl/fw_ram_scrub_timeout.sv
// Loadable down-counter bounding how long one bus access may wait for mem_ready.
module fw_ram_scrub_timeout
  import fw_ram_scrubber_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 32'd1);
  // Loading TIMEOUT-1 makes expiry coincide with the TIMEOUT-th waiting cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 32'd1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Next count: reload on access entry, otherwise count down to zero and hold.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = LOAD_VAL;
    end else if (enable && (count != {CNT_W{1'b0}})) begin
      count_next = count - CNT_W'(1);
    end else begin
      count_next = count;
    end
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= {CNT_W{1'b0}};
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == {CNT_W{1'b0}});
    end
  end

endmodule

// File: rtl/fw_ram_scrubber.sv
// Fills NUM_WORDS words of FW RAM with FILL_WORD; define FW_RAM_SCRUB_VERIFY_EN
// to read every word back and flag a mismatch.
module fw_ram_scrubber
  import fw_ram_scrubber_pkg::*;
#(
  parameter int unsigned       NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [DATA_W-1:0] FILL_WORD = DEF_FILL_WORD,
  parameter int unsigned       TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 32'd1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;

  logic       busy_next;
  logic       done_next;
  logic       error_next;
  logic       cs_next;
  logic [3:0] we_next;

  logic tmo_load;
  logic tmo_enable;
  logic tmo_expired;

`ifdef FW_RAM_SCRUB_VERIFY_EN
  logic read_bad;
  assign read_bad = (mem_read_data != FILL_WORD);
`else
  logic read_data_unused;
  assign read_data_unused = ^mem_read_data;
`endif

  assign tmo_load   = is_access(next_state) && (next_state != state);
  assign tmo_enable = is_access(state);

  fw_ram_scrub_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmo_load),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // State and address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      addr  <= {ADDR_W{1'b0}};
    end else begin
      state <= next_state;
      addr  <= next_addr;
    end
  end

  // Next-state and address sequencing; the gap states ignore the stale ack.
  always_comb begin
    next_state = state;
    next_addr  = addr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_WRITE;
          next_addr  = {ADDR_W{1'b0}};
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          next_state = ST_WGAP;
        end else if (tmo_expired) begin
          next_state = ST_FINISH;
        end else begin
          next_state = ST_WRITE;
        end
      end
      ST_WGAP: begin
`ifdef FW_RAM_SCRUB_VERIFY_EN
        next_state = ST_READ;
`else
        if (addr == LAST_ADDR) begin
          next_state = ST_FINISH;
        end else begin
          next_state = ST_WRITE;
          next_addr  = addr + ADDR_W'(1);
        end
`endif
      end
`ifdef FW_RAM_SCRUB_VERIFY_EN
      ST_READ: begin
        if (mem_ready) begin
          if (read_bad) begin
            next_state = ST_FINISH;
          end else begin
            next_state = ST_RGAP;
          end
        end else if (tmo_expired) begin
          next_state = ST_FINISH;
        end else begin
          next_state = ST_READ;
        end
      end
      ST_RGAP: begin
        if (addr == LAST_ADDR) begin
          next_state = ST_FINISH;
        end else begin
          next_state = ST_WRITE;
          next_addr  = addr + ADDR_W'(1);
        end
      end
`endif
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming state; leaving an access straight to FINISH is a failure.
  always_comb begin
    cs_next   = is_access(next_state);
    we_next   = (next_state == ST_WRITE) ? WE_WRITE : WE_READ;
    busy_next = is_active(next_state);
    done_next = (next_state == ST_FINISH);
    if ((state == ST_IDLE) && start) begin
      error_next = 1'b0;
    end else if (is_access(state) && (next_state == ST_FINISH)) begin
      error_next = 1'b1;
    end else begin
      error_next = error;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      mem_cs <= 1'b0;
      mem_we <= WE_READ;
    end else begin
      busy   <= busy_next;
      done   <= done_next;
      error  <= error_next;
      mem_cs <= cs_next;
      mem_we <= we_next;
    end
  end

  assign mem_address    = addr;
  assign mem_write_data = FILL_WORD;

endmodule

// File: tb/tb_fw_ram_scrubber.sv
// Scoreboard bench for fw_ram_scrubber; stimulus queues expectations, a monitor checks them.
module tb_fw_ram_scrubber;

`ifdef FW_RAM_SCRUB_VERIFY_EN
  localparam int WLAT = 6;
`else
  localparam int WLAT = 3;
`endif
  localparam int NW = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error, mem_cs, mem_ready;
  logic [3:0]  mem_we;
  logic [8:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;

  int stall_addr = -1;
  int bad_addr = -1;

  typedef struct {
    bit err;
    int lat;
    int hi;
    int run;
    bit counts;
  } done_t;

  int    exp_wq[$];
  done_t exp_done[$];
  int    exp_rst[$];
  string tmo_q[$];

  int checks = 0;
  int failures = 0;

  // monitor-owned state
  int    cyc = 0, start_cyc = 0, hi = -1, cs_run = 0, last_run = 0, a = 0, bad = 0;
  bit    err_model = 1'b0, after_start = 1'b0, after_done = 1'b0, rst_prev = 1'b1;
  int    wcnt [NW];
  done_t rec;

  fw_ram_scrubber dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_cs         (mem_cs),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  // Responder: ready is a registered copy of cs, withheld at the stalled address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_ready <= 1'b0;
    else          mem_ready <= mem_cs && (int'(mem_address) != stall_addr);
  end
  assign mem_read_data = (int'(mem_address) == bad_addr) ? 32'h0000_0001 : 32'h0000_0000;

  initial begin : monitor
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        if (rst_prev) begin
          #1;
          checks++;
          if (exp_rst.size() == 0) begin
            failures++;
            $display("FAIL unexpected_reset: actual=reset seen required=no reset");
          end else begin
            void'(exp_rst.pop_front());
          end
          checks++;
          if ({busy, done, error, mem_cs, mem_we, mem_address} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b error=%b cs=%b we=%h addr=%0d required all zero",
                     busy, done, error, mem_cs, mem_we, mem_address);
          end
          checks++;
          if (exp_wq.size() != 0 || exp_done.size() != 0) begin
            failures++;
            $display("FAIL abort_pending: writes=%0d dones=%0d required 0 and 0", exp_wq.size(), exp_done.size());
          end
          err_model = 1'b0; after_start = 1'b0; after_done = 1'b0; cs_run = 0; hi = -1;
        end
        rst_prev = 1'b0;
      end else begin
        rst_prev = 1'b1;
        cyc++;
        while (tmo_q.size() != 0) begin
          checks++;
          failures++;
          $display("FAIL timeout_%s: actual=event missing required=event within budget", tmo_q.pop_front());
        end
        if (after_start) begin
          checks++;
          if (!(busy === 1'b1 && error === 1'b0)) begin
            failures++;
            $display("FAIL start_ack: busy=%b error=%b required busy=1 error=0", busy, error);
          end
          after_start = 1'b0;
        end
        if (after_done) begin
          checks++;
          if (!(done === 1'b0 && busy === 1'b0 && error === err_model)) begin
            failures++;
            $display("FAIL after_done: done=%b busy=%b error=%b required done=0 busy=0 error=%b",
                     done, busy, error, err_model);
          end
          after_done = 1'b0;
        end
        checks++;
        if (!(mem_cs === 1'b1 || mem_we === 4'h0)) begin
          failures++;
          $display("FAIL we_idle: we=%h with cs low required 0", mem_we);
        end
        if (mem_cs === 1'b1) begin
          cs_run++;
          if (int'(mem_address) > hi) hi = int'(mem_address);
        end else if (cs_run != 0) begin
          last_run = cs_run;
          cs_run = 0;
        end
        if (mem_cs === 1'b1 && mem_ready === 1'b1) begin
          checks++;
          if (mem_we === 4'hf) begin
            wcnt[mem_address]++;
            if (exp_wq.size() == 0) begin
              failures++;
              $display("FAIL unexpected_write: addr=%0d required no write", mem_address);
            end else begin
              a = exp_wq.pop_front();
              if (int'(mem_address) != a || mem_write_data !== 32'h0000_0000) begin
                failures++;
                $display("FAIL write: addr=%0d data=%h required addr=%0d data=00000000",
                         mem_address, mem_write_data, a);
              end
            end
          end
`ifdef FW_RAM_SCRUB_VERIFY_EN
          else if (mem_we !== 4'h0) begin
            failures++;
            $display("FAIL bad_we: we=%h required f or 0", mem_we);
          end
`else
          else begin
            failures++;
            $display("FAIL unexpected_access: we=%h required f", mem_we);
          end
`endif
        end
        if (done === 1'b1) begin
          checks++;
          if (exp_done.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: actual=done pulse required=none");
          end else begin
            rec = exp_done.pop_front();
            if (error !== rec.err || busy !== 1'b0 || (cyc - start_cyc - 1) != rec.lat ||
                hi != rec.hi || last_run != rec.run || exp_wq.size() != 0) begin
              failures++;
              $display("FAIL done: error=%b busy=%b lat=%0d hi=%0d run=%0d pending=%0d required error=%b busy=0 lat=%0d hi=%0d run=%0d pending=0",
                       error, busy, cyc - start_cyc - 1, hi, last_run, exp_wq.size(),
                       rec.err, rec.lat, rec.hi, rec.run);
            end
            if (rec.counts) begin
              checks++;
              bad = 0;
              for (int i = 0; i < NW; i++) if (wcnt[i] != 1) bad++;
              if (bad != 0) begin
                failures++;
                $display("FAIL write_once: addresses not written exactly once=%0d required 0", bad);
              end
            end
            err_model = rec.err;
            after_done = 1'b1;
          end
        end
        if (start === 1'b1 && busy === 1'b0 && done === 1'b0) begin
          start_cyc = cyc;
          hi = -1;
          err_model = 1'b0;
          after_start = 1'b1;
          for (int i = 0; i < NW; i++) wcnt[i] = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    tmo_q.push_back(name);
  endtask

  task automatic wait_write_at(input int addr, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_cs === 1'b1 && mem_we === 4'hf && int'(mem_address) == addr) return;
    end
    tmo_q.push_back(name);
  endtask

  task automatic push_writes(input int first, input int last);
    for (int i = first; i <= last; i++) exp_wq.push_back(i);
  endtask

  task automatic push_done(input bit err, input int lat, input int hi_a, input int run, input bit counts);
    done_t r;
    r.err = err; r.lat = lat; r.hi = hi_a; r.run = run; r.counts = counts;
    exp_done.push_back(r);
  endtask

  initial begin : stimulus
    exp_rst.push_back(0);
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // full scrub; stale ready in every WGAP must not cause extra or skipped writes
    push_writes(0, NW - 1);
    push_done(1'b0, NW * WLAT, NW - 1, 2, 1'b1);
    pulse_start();
    wait_done(NW * WLAT + 50, "full_scrub");
    repeat (4) @(posedge clk);

    // responder never acks address 37
    stall_addr = 37;
    push_writes(0, 36);
    push_done(1'b1, 37 * WLAT + 16, 37, 16, 1'b0);
    pulse_start();
    wait_done(37 * WLAT + 100, "stall_scrub");
    repeat (4) @(posedge clk);
    stall_addr = -1;

`ifdef FW_RAM_SCRUB_VERIFY_EN
    // read-back of address 100 returns a wrong word
    bad_addr = 100;
    push_writes(0, 100);
    push_done(1'b1, 100 * WLAT + 5, 100, 2, 1'b0);
    pulse_start();
    wait_done(100 * WLAT + 100, "verify_scrub");
    repeat (4) @(posedge clk);
    bad_addr = -1;
`endif

    // repeated start while busy, then reset in the middle of the write to 200
    push_writes(0, 199);
    pulse_start();
    repeat (60) @(posedge clk);
    pulse_start();
    repeat (7) @(posedge clk);
    pulse_start();
    wait_write_at(200, 250 * WLAT, "reach_addr_200");
    #2;
    exp_rst.push_back(1);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);

    // a fresh start after the abort begins again at address 0
    push_writes(0, NW - 1);
    push_done(1'b0, NW * WLAT, NW - 1, 2, 1'b1);
    pulse_start();
    wait_done(NW * WLAT + 50, "restart_scrub");
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
